// File: rtl/rsa_pkg.sv
// Shared definitions for the systolic-array row result collector.
//   - Q1.12.19 data format constants and the default data width derived from them
//   - FSM state encoding for the collector's burst framer
//   - Default result-entry packing width {data, column index, last}
package rsa_pkg;

  localparam int INT_BIT    = 12;
  localparam int DEC_BIT    = 19;
  // Sign bit + integer bits + fraction bits.
  localparam int RSA_DW_DEF = 1 + INT_BIT + DEC_BIT;
  localparam int IDX_W_DEF  = 2;

  // One FIFO entry carries the result, its column index and the last flag.
  localparam int ENTRY_W_DEF = RSA_DW_DEF + IDX_W_DEF + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/rsa_sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (pointers and count only)
//   push   : write wdata; accepted when not full, or when full with a pop
//            in the same cycle
//   pop    : remove the head entry; ignored when empty
//   wdata  : entry to write
//   rdata  : current head entry (valid whenever empty is low)
//   full   : DEPTH entries held
//   empty  : no entries held
module rsa_sync_fifo import rsa_pkg::*; #(
  parameter int W     = ENTRY_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are power-of-two wide, so the increment wraps naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rsa_row_collector.sv
// West-edge result collector for one systolic-array row.
// Frames the PE result stream into bursts of RSA_COL results, tags each
// with its column index and a last flag, and buffers them for a
// valid/ready consumer.
//   clk, sys_rst_n   : clock, asynchronous active-low reset
//   mulres_val/mulres: result stream from the westmost PE (no backpressure)
//   out_valid/out_ready/out_data/out_idx/out_last : buffered result output
//   burst_done       : one-cycle pulse after the last result of a burst
//   err_short        : sticky, a burst ended before RSA_COL results
//   err_ovf          : sticky, a result was dropped on a full FIFO
//   err_clr          : synchronous clear of both sticky flags
//   dbg_state        : current framer FSM state (ST_IDLE / ST_BURST)
//
// Output handshake: an entry transfers on a cycle where out_valid and
// out_ready are both high at the rising edge; while out_valid is high and
// out_ready is low, out_data/out_idx/out_last hold. Outputs read as zero
// when out_valid is low.
module rsa_row_collector import rsa_pkg::*; #(
  parameter int RSA_DW     = RSA_DW_DEF,
  parameter int RSA_COL    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     mulres_val,
  input  logic signed [RSA_DW-1:0] mulres,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RSA_DW-1:0] out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     burst_done,
  output logic                     err_short,
  output logic                     err_ovf,
  input  logic                     err_clr,
  output logic [0:0]               dbg_state
);

  localparam int               EW       = RSA_DW + IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RSA_COL - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] col_cnt_q, col_cnt_d;
  logic             burst_done_q, burst_done_d;
  logic             err_short_q, err_short_d;
  logic             err_ovf_q, err_ovf_d;

  logic             capture;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_last;
  logic             short_evt;
  logic             ovf_evt;

  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // Framer: every valid is captured; the counter advances even when the
  // entry is dropped so that burst boundaries stay aligned.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    capture   = 1'b0;
    cap_idx   = col_cnt_q;
    cap_last  = 1'b0;
    short_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mulres_val) begin
          capture   = 1'b1;
          cap_idx   = '0;
          state_d   = ST_BURST;
          col_cnt_d = IDX_W'(1);
        end
      end
      ST_BURST: begin
        if (mulres_val) begin
          capture = 1'b1;
          cap_idx = col_cnt_q;
          if (col_cnt_q == LAST_IDX) begin
            cap_last  = 1'b1;
            state_d   = ST_IDLE;
            col_cnt_d = '0;
          end else begin
            col_cnt_d = col_cnt_q + IDX_W'(1);
          end
        end else begin
          short_evt = 1'b1;
          state_d   = ST_IDLE;
          col_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        col_cnt_d = '0;
      end
    endcase
  end

  assign pop      = out_valid && out_ready;
  assign ovf_evt  = capture && fifo_full && !pop;
  assign wr_entry = {mulres, cap_idx, cap_last};

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    burst_done_d = capture && cap_last;
    err_short_d  = short_evt ? 1'b1 : (err_clr ? 1'b0 : err_short_q);
    err_ovf_d    = ovf_evt   ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      col_cnt_q    <= '0;
      burst_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      burst_done_q <= burst_done_d;
      err_short_q  <= err_short_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  rsa_sync_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .push  (capture),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  // Mask the uninitialised head so outputs read zero when nothing is held.
  assign out_data   = out_valid ? rd_entry[EW-1 -: RSA_DW] : '0;
  assign out_idx    = out_valid ? rd_entry[IDX_W:1]        : '0;
  assign out_last   = out_valid ? rd_entry[0]              : 1'b0;
  assign burst_done = burst_done_q;
  assign err_short  = err_short_q;
  assign err_ovf    = err_ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rsa_row_collector.sv
module tb_rsa_row_collector;
  import rsa_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        sys_rst_n;
  logic        mulres_val;
  logic [31:0] mulres;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        burst_done;
  logic        err_short;
  logic        err_ovf;
  logic        err_clr;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected entries {data, idx, last}, filled by hand before each drain.
  logic [34:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rsa_row_collector dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .mulres_val (mulres_val),
    .mulres     (mulres),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .burst_done (burst_done),
    .err_short  (err_short),
    .err_ovf    (err_ovf),
    .err_clr    (err_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".valid"},  64'(out_valid),  64'd0);
    chk({tag, ".data"},   64'(out_data),   64'd0);
    chk({tag, ".idx"},    64'(out_idx),    64'd0);
    chk({tag, ".last"},   64'(out_last),   64'd0);
    chk({tag, ".done"},   64'(burst_done), 64'd0);
    chk({tag, ".eshort"}, 64'(err_short),  64'd0);
    chk({tag, ".eovf"},   64'(err_ovf),    64'd0);
    chk({tag, ".state"},  64'(dbg_state),  64'(ST_IDLE));
  endtask

  task automatic chk_head(input string tag, input logic [34:0] e);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".data"},  64'(out_data),  64'(e[34:3]));
    chk({tag, ".idx"},   64'(out_idx),   64'(e[2:1]));
    chk({tag, ".last"},  64'(out_last),  64'(e[0]));
  endtask

  // With out_ready=1 and an empty FIFO, the pushed value is the head one
  // cycle later.
  task automatic push_chk(input string tag, input logic [31:0] d,
                          input logic [1:0] idx, input logic last);
    mulres_val = 1'b1;
    mulres     = d;
    tick();
    chk_head(tag, {d, idx, last});
  endtask

  task automatic push_only(input logic [31:0] d);
    mulres_val = 1'b1;
    mulres     = d;
    tick();
  endtask

  task automatic idle_tick();
    mulres_val = 1'b0;
    mulres     = '0;
    tick();
  endtask

  // Scoreboard drain: out_ready must be 1; checks and pops each expected entry.
  task automatic drain_chk(input string tag);
    logic [34:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_head(tag, e);
      tick();
    end
    chk({tag, ".empty"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sys_rst_n  = 1'b0;
    mulres_val = 1'b0;
    mulres     = '0;
    out_ready  = 1'b1;
    err_clr    = 1'b0;
    #2;
    chk_zero_outputs("rst");
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Single burst with out_ready held high.
    push_chk("b1.0", 32'd10,       2'd0, 1'b0);
    chk("b1.0.done", 64'(burst_done), 64'd0);
    push_chk("b1.1", 32'hFFFFFFEC, 2'd1, 1'b0);
    push_chk("b1.2", 32'd30,       2'd2, 1'b0);
    push_chk("b1.3", 32'h7FFFFFFF, 2'd3, 1'b1);
    chk("b1.done", 64'(burst_done), 64'd1);
    idle_tick();
    chk("b1.done_end", 64'(burst_done), 64'd0);
    chk("b1.valid_end", 64'(out_valid), 64'd0);
    chk("b1.eshort", 64'(err_short), 64'd0);
    chk("b1.eovf", 64'(err_ovf), 64'd0);

    // Back-to-back bursts, values 1..8.
    for (int i = 1; i <= 8; i++) begin
      push_chk("b2", 32'(i), 2'((i - 1) % 4), (i % 4) == 0);
      chk("b2.done", 64'(burst_done), 64'((i % 4) == 0));
    end
    idle_tick();
    chk("b2.eshort", 64'(err_short), 64'd0);

    // Short burst followed by a full one.
    push_chk("s.0", 32'd5, 2'd0, 1'b0);
    push_chk("s.1", 32'd6, 2'd1, 1'b0);
    chk("s.state", 64'(dbg_state), 64'(ST_BURST));
    idle_tick();
    chk("s.eshort", 64'(err_short), 64'd1);
    chk("s.valid", 64'(out_valid), 64'd0);
    chk("s.done", 64'(burst_done), 64'd0);
    push_chk("s.r0", 32'd11, 2'd0, 1'b0);
    push_chk("s.r1", 32'd12, 2'd1, 1'b0);
    push_chk("s.r2", 32'd13, 2'd2, 1'b0);
    push_chk("s.r3", 32'd14, 2'd3, 1'b1);
    idle_tick();

    // Overflow: 12 results into 8 entries, consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_only(32'h100 + 32'(i));
      if (i == 7) chk("ovf.before", 64'(err_ovf), 64'd0);
      if (i == 8) chk("ovf.set", 64'(err_ovf), 64'd1);
    end
    idle_tick();
    chk("ovf.eshort", 64'(err_short), 64'd1);
    chk_head("ovf.hold", {32'h100, 2'd0, 1'b0});
    for (int i = 0; i < 8; i++)
      exp_q.push_back({32'h100 + 32'(i), 2'(i % 4), (i % 4) == 3});
    out_ready = 1'b1;
    drain_chk("ovf.drain");
    chk("ovf.sticky", 64'(err_ovf), 64'd1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr.eovf", 64'(err_ovf), 64'd0);
    chk("clr.eshort", 64'(err_short), 64'd0);

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_only(32'h200 + 32'(i));
    chk("fpp.full_eovf", 64'(err_ovf), 64'd0);
    out_ready  = 1'b1;
    mulres_val = 1'b1;
    mulres     = 32'h2FF;
    tick();
    out_ready  = 1'b0;
    mulres_val = 1'b0;
    chk("fpp.eovf", 64'(err_ovf), 64'd0);
    chk_head("fpp.head", {32'h201, 2'd1, 1'b0});
    // The 0x2FF burst is cut short here; only the overflow flag matters.
    tick();
    chk("fpp.eovf2", 64'(err_ovf), 64'd0);
    for (int i = 1; i < 8; i++)
      exp_q.push_back({32'h200 + 32'(i), 2'(i % 4), (i % 4) == 3});
    exp_q.push_back({32'h2FF, 2'd0, 1'b0});
    out_ready = 1'b1;
    drain_chk("fpp.drain");

    // Asynchronous reset mid-burst with entries held and a sticky flag set.
    chk("ar.eshort_pre", 64'(err_short), 64'd1);
    out_ready = 1'b0;
    push_only(32'h31);
    push_only(32'h32);
    mulres_val = 1'b0;
    chk("ar.state_pre", 64'(dbg_state), 64'(ST_BURST));
    chk("ar.valid_pre", 64'(out_valid), 64'd1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk_zero_outputs("ar");
    tick();
    tick();
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push_chk("ar.r0", 32'h41, 2'd0, 1'b0);
    push_chk("ar.r1", 32'h42, 2'd1, 1'b0);
    push_chk("ar.r2", 32'h43, 2'd2, 1'b0);
    push_chk("ar.r3", 32'h44, 2'd3, 1'b1);
    idle_tick();

    // Sticky clear without and with a coincident error event.
    push_only(32'h51);
    idle_tick();
    chk("ec.set", 64'(err_short), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ec.clear", 64'(err_short), 64'd0);
    chk("ec.clear_ovf", 64'(err_ovf), 64'd0);
    push_only(32'h61);
    mulres_val = 1'b0;
    err_clr    = 1'b1;
    tick();
    chk("ec.set_wins", 64'(err_short), 64'd1);
    tick();
    err_clr = 1'b0;
    chk("ec.clear2", 64'(err_short), 64'd0);
    chk("ec.valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
